// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache
//               controller between a 32-bit word processor port and a
//               128-bit block-wide memory with a read/write/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = 3,
  parameter int TAG_W      = 28 - INDEX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_ARM  = 3'd1,
    WB_WAIT = 3'd2,
    AL_ARM  = 3'd3,
    AL_WAIT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]       tag_d  [NUM_BLOCKS];
  logic [127:0]           data_q [NUM_BLOCKS];
  logic [127:0]           data_d [NUM_BLOCKS];
  logic [INDEX_W-1:0]     idx_q, idx_d;
  logic [TAG_W-1:0]       ltag_q, ltag_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [27:0]            mem_addr_q, mem_addr_d;
  logic [127:0]           mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0]     w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [6:0]             w_bit;
  logic                   w_req;
  logic                   w_hit;

  assign w_idx = proc_addr[INDEX_W+1:2];
  assign w_tag = proc_addr[29:INDEX_W+2];
  assign w_bit = {proc_addr[1:0], 5'b0};
  assign w_req = proc_read | proc_write;
  assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

  assign proc_rdata = data_q[w_idx][w_bit +: 32];
  // A miss stalls even in IDLE so the pipeline never sees stale load data.
  assign proc_stall = (state_q != IDLE) || (w_req && !w_hit);

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, array update and memory request generation.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    idx_d       = idx_q;
    ltag_d      = ltag_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            // Write wins over read when both are requested.
            if (proc_write) begin
              data_d[w_idx][w_bit +: 32] = proc_wdata;
              dirty_d[w_idx]             = 1'b1;
            end
          end else begin
            idx_d  = w_idx;
            ltag_d = w_tag;
            if (valid_q[w_idx] && dirty_q[w_idx]) begin
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[w_idx], w_idx};
              mem_wdata_d = data_q[w_idx];
              state_d     = WB_ARM;
            end else begin
              mem_read_d = 1'b1;
              mem_addr_d = proc_addr[29:2];
              state_d    = AL_ARM;
            end
          end
        end
      end
      // ARM states wait for ready to drop so a lingering ready from the
      // previous transaction is never mistaken for completion.
      WB_ARM: begin
        if (mem_ready == 1'b0) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_ready == 1'b1) begin
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {ltag_q, idx_q};
          state_d     = AL_ARM;
        end
      end
      AL_ARM: begin
        if (mem_ready == 1'b0) state_d = AL_WAIT;
      end
      AL_WAIT: begin
        if (mem_ready == 1'b1) begin
          data_d[idx_q]  = mem_rdata;
          tag_d[idx_q]   = ltag_q;
          valid_d[idx_q] = 1'b1;
          dirty_d[idx_q] = 1'b0;
          mem_read_d     = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits and memory request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      idx_q       <= '0;
      ltag_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      idx_q       <= idx_d;
      ltag_q      <= ltag_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data storage: never cleared, frozen while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_cache_ctrl
// Description : Scoreboard bench for dm_cache_ctrl with a behavioural
//               block memory that can hold ready high past completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dm_cache_ctrl #(.NUM_BLOCKS(8), .INDEX_W(3), .TAG_W(25)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         w;
    logic [27:0]  a;
    logic [127:0] d;
  } mreq_t;

  int           total = 0;
  int           bad   = 0;
  int           stale_extra = 0;
  logic [31:0]  exp_rd_q [$];
  mreq_t        exp_mem_q [$];
  logic [127:0] mem_model [logic [27:0]];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic w, input logic [27:0] a, input logic [127:0] d);
    mreq_t m;
    m.w = w; m.a = a; m.d = d;
    exp_mem_q.push_back(m);
  endtask

  // Processor driver: call at posedge+1; holds the request while stalled.
  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] wd, output int stalls);
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!proc_stall) break;
      stalls++;
    end
    if (proc_stall) begin
      total++; bad++;
      $display("FAIL access_timeout addr=%h actual=stalled required=released", a);
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  // Behavioural memory: serves after MEM_LAT cycles, holds ready until the
  // request changes, optionally for stale_extra more cycles.
  initial begin : mem_p
    logic        cur_w;
    logic [27:0] cur_a;
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(posedge clk); #1;
    forever begin
      if (rst_n === 1'b1 && (mem_read || mem_write)) begin
        cur_w = mem_write; cur_a = mem_addr;
        repeat (MEM_LAT) @(posedge clk);
        #1;
        if (rst_n === 1'b1 && (mem_read || mem_write)) begin
          if (cur_w) mem_model[cur_a] = mem_wdata;
          else       mem_rdata = mem_model[cur_a];
          mem_ready = 1'b1;
          do begin
            @(posedge clk); #1;
          end while (rst_n === 1'b1 && mem_write == cur_w && mem_read == !cur_w && mem_addr == cur_a);
          repeat (stale_extra) begin
            @(posedge clk); #1;
          end
          mem_ready = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Load-data monitor: a read that is not stalled presents proc_rdata.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && proc_read === 1'b1 && proc_write === 1'b0 && proc_stall === 1'b0) begin
      if (exp_rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rdata_unexpected actual=%h required=none", proc_rdata);
      end else begin
        chk("proc_rdata", proc_rdata, exp_rd_q.pop_front());
      end
    end
  end

  // Memory-request monitor plus handshake invariants.
  logic        prev_act = 1'b0;
  logic        prev_w   = 1'b0;
  logic [27:0] prev_a   = '0;
  mreq_t       mon_m;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((mem_read || mem_write) && !(prev_act && prev_w == mem_write && prev_a == mem_addr)) begin
        if (exp_mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_req_unexpected actual=w%0b addr=%h required=none", mem_write, mem_addr);
        end else begin
          mon_m = exp_mem_q.pop_front();
          chk("mem_is_write", {127'd0, mem_write}, {127'd0, mon_m.w});
          chk("mem_addr", {100'd0, mem_addr}, {100'd0, mon_m.a});
          if (mon_m.w) chk("mem_wdata", mem_wdata, mon_m.d);
        end
      end
      if (mem_read || mem_write) begin
        chk("one_hot_rw", {127'd0, mem_read & mem_write}, 128'd0);
        chk("stall_during_mem", {127'd0, proc_stall}, 128'd1);
      end
    end
    prev_act <= (rst_n === 1'b1) && (mem_read || mem_write);
    prev_w   <= mem_write;
    prev_a   <= mem_addr;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int st;
    mem_model[28'h1]  = 128'h00000033_00000022_00000011_00000000;
    mem_model[28'h9]  = 128'h00000093_00000092_00000091_00000090;
    mem_model[28'h10] = 128'h000000A3_000000A2_000000A1_000000A0;
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {127'd0, proc_stall}, 128'd0);
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
    chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Cold read miss, then hit in the same block.
    push_mem(1'b0, 28'h1, '0); exp_rd_q.push_back(32'h0000_0000);
    access(1'b1, 1'b0, 30'h4, '0, st);
    chk("cold_stall_cycles", st, 128'd4);
    exp_rd_q.push_back(32'h0000_0011);
    access(1'b1, 1'b0, 30'h5, '0, st);
    chk("hit_read_stall", st, 128'd0);

    // Write hit, then dirty eviction by same index, new tag.
    access(1'b0, 1'b1, 30'h6, 32'hDEADBEEF, st);
    chk("hit_write_stall", st, 128'd0);
    push_mem(1'b1, 28'h1, 128'h00000033_DEADBEEF_00000011_00000000);
    push_mem(1'b0, 28'h9, '0);
    exp_rd_q.push_back(32'h0000_0092);
    access(1'b1, 1'b0, 30'h26, '0, st);
    chk("dirty_evict_stall", st, 128'd7);

    // Clean eviction: only a fill, returning the written-back word.
    push_mem(1'b0, 28'h1, '0);
    exp_rd_q.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 30'h6, '0, st);
    chk("clean_evict_stall", st, 128'd4);

    // Stale ready held 3 cycles past write-back completion.
    access(1'b0, 1'b1, 30'h6, 32'h12345678, st);
    chk("hit_write2_stall", st, 128'd0);
    stale_extra = 3;
    push_mem(1'b1, 28'h1, 128'h00000033_12345678_00000011_00000000);
    push_mem(1'b0, 28'h9, '0);
    exp_rd_q.push_back(32'h0000_0091);
    fork
      access(1'b1, 1'b0, 30'h25, '0, st);
      begin : stale_watch
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_read !== 1'b1 && n < 50);
        chk("stale_arm0_mem_read", {127'd0, mem_read}, 128'd1);
        @(negedge clk);
        chk("stale_arm1_mem_read", {127'd0, mem_read}, 128'd1);
        @(negedge clk);
        chk("stale_arm2_mem_read", {127'd0, mem_read}, 128'd1);
      end
    join
    chk("stale_stall_cycles", st, 128'd10);
    stale_extra = 0;
    repeat (6) @(posedge clk);
    #1;

    // Read+write together on a hit: behaves as a write and marks dirty.
    access(1'b1, 1'b1, 30'h27, 32'hCAFEF00D, st);
    chk("rw_hit_stall", st, 128'd0);
    exp_rd_q.push_back(32'hCAFEF00D);
    access(1'b1, 1'b0, 30'h27, '0, st);
    push_mem(1'b1, 28'h9, 128'hCAFEF00D_00000092_00000091_00000090);
    push_mem(1'b0, 28'h1, '0);
    exp_rd_q.push_back(32'h0000_0011);
    access(1'b1, 1'b0, 30'h5, '0, st);
    chk("rw_evict_stall", st, 128'd7);

    // Reset during the fill wait.
    push_mem(1'b0, 28'h10, '0);
    proc_read = 1'b1; proc_addr = 30'h40;
    begin : wait_fill
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (mem_read !== 1'b1 && n < 50);
      chk("midfill_req_seen", {127'd0, mem_read}, 128'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; proc_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midfill_rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("midfill_rst_stall", {127'd0, proc_stall}, 128'd0);
    chk("midfill_rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push_mem(1'b0, 28'h10, '0);
    exp_rd_q.push_back(32'h0000_00A0);
    access(1'b1, 1'b0, 30'h40, '0, st);
    chk("post_rst_miss_stall", st, 128'd4);

    repeat (5) @(posedge clk);
    chk("mem_queue_drained", exp_mem_q.size(), 128'd0);
    chk("rd_queue_drained", exp_rd_q.size(), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the MIPS pipeline (32-bit word port) and the 128-bit block-wide slow memory.
- Acts as the initiator of the memory read/write/ready handshake. Stalls the processor on any miss until the block is resident.

Parameters:
NUM_BLOCKS, 8, number of cache lines (power of 2)
INDEX_W, 3, log2(NUM_BLOCKS)
TAG_W, 25, 28 - INDEX_W; block-address bits stored per line

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
proc_read  input  1  processor load request
proc_write  input  1  processor store request
proc_addr  input  30  word address; [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
proc_wdata  input  32  store data
proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0
proc_stall  output  1  processor must hold its request stable while high
mem_read  output  1  block read request to memory
mem_write  output  1  block write request to memory
mem_addr  output  28  block address (proc_addr[29:2] form)
mem_wdata  output  128  write-back block; word 0 in [31:0]
mem_rdata  input  128  fill block from memory
mem_ready  input  1  memory completion; stays high until memory next samples an idle or new request

Behaviour:
- Reset (rst_n=0 at posedge):
  - all valid and dirty bits cleared; state=IDLE.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Tag and data arrays are not cleared.
  - proc_stall is combinational and follows the IDLE rules.
  - Reset mid-transaction abandons that transaction; the next miss restarts from the ARM states.
- Request decode: proc_write has priority when both proc_read and proc_write are 1. No request means proc_stall=0.
- Hit: line[index] is valid and its tag matches.
- IDLE:
  - Read hit: proc_stall=0; proc_rdata = selected word, combinational, same cycle.
  - Write hit: proc_stall=0; word written and dirty set at the posedge.
  - Miss:
    - proc_stall=1; latch index, tag and the victim block.
    - Victim valid and dirty: go to WB_ARM with mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block.
    - Otherwise: go to AL_ARM with mem_read=1, mem_addr=proc_addr[29:2].
- WB_ARM: hold mem_write. Go to WB_WAIT on the first cycle mem_ready==0 (stale high ready from a prior transaction is ignored; X is not treated as 0).
- WB_WAIT:
  - Hold mem_write until mem_ready==1.
  - Then at that posedge: deassert mem_write, assert mem_read, mem_addr={latched tag,index}, go to AL_ARM.
- AL_ARM: hold mem_read. Go to AL_WAIT on mem_ready==0.
- AL_WAIT:
  - On mem_ready==1: write mem_rdata into the line, set tag, valid=1, dirty=0; deassert mem_read; go to IDLE.
  - The access then hits on the next cycle, so a clean miss costs (memory time + 1) cycles of stall.
- proc_stall = 1 in every non-IDLE state, and in IDLE on a miss.
- Exactly one of mem_read/mem_write is high at any time, and only in a non-IDLE state.
- mem_addr and mem_wdata are stable for the whole duration of each request.
- Processor inputs are not sampled outside IDLE. The processor must hold its request while stalled; the controller re-evaluates the live inputs on return to IDLE.
- Index wrap: different tags on the same index evict each other. Capacity is NUM_BLOCKS*4 words.

Test Plan:
- Cold read: reset, then proc_read addr 0x0000004 with mem block = {0x33,0x22,0x11,0x00}.
  - Required: mem_read=1 with mem_addr=0x0000001; proc_stall held through the fill.
  - Next cycle: proc_rdata=0x00000000, stall=0.
  - A subsequent read of 0x0000005 returns 0x00000011 with zero stall and no mem activity.
- Write hit then evict:
  - Write 0xDEADBEEF to 0x0000006 (hit) → zero stall.
  - Read 0x0000026 (same index 1, new tag) → mem_write=1, mem_addr=0x0000001, mem_wdata[95:64]=0xDEADBEEF; then mem_read, mem_addr=0x0000009.
- Clean eviction: read 0x0000006 after a clean fill of 0x0000026 → no mem_write; only mem_read, mem_addr=0x0000001.
- Stale ready: hold mem_ready=1 for 3 cycles after the write-back completes → controller stays in AL_ARM. It must not capture mem_rdata until ready has gone 0 then 1.
- Reset mid-fill: assert rst_n=0 during AL_WAIT.
  - Next posedge: mem_read=0, stall reflects IDLE.
  - A read of the same address misses again (valid cleared).
- Simultaneous read and write to a hit address → treated as a write: array updated, dirty=1.
